branch_resolver: RTL and testbench

Execute-stage branch resolution unit. It evaluates conditional branches, compares each outcome with the prediction IF attached to the instruction, and redirects and flushes the front end on a mispredict. It is the writer side of the 2-bit-counter branch predictor. It drives the predictor's update port (`flag`/`addr`/`branch`) once per resolved branch.

---
 rtl/branch_resolver.sv | 139 +++++++++++++
 tb/tb_branch_resolver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates the condition, updates the 2-bit predictor, redirects IF and flushes IF/ID on mispredict.
// All outputs are registered, one cycle after acceptance; ready_out drops for FLUSH_CYCLES after a mispredict. Optional counters under BRANCH_STAT_EN.
module branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned IDX_LSB      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic        pred_in,
    output logic        flag_to_pred,
    output logic [7:0]  addr_to_pred,
    output logic        branch_to_pred,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ready_q, flush_q, flag_q, branch_q, redirect_valid_q;
    logic [7:0]  addr_q;
    logic [31:0] redirect_pc_q;

    logic        taken_c, legal_c, upd_c, mis_c;
    logic [31:0] next_pc_c;

    always_comb begin
        taken_c = 1'b0;
        case (funct3_in)
            3'b000:  taken_c = (rs1_in == rs2_in);
            3'b001:  taken_c = (rs1_in != rs2_in);
            3'b100:  taken_c = ($signed(rs1_in) <  $signed(rs2_in));
            3'b101:  taken_c = ($signed(rs1_in) >= $signed(rs2_in));
            3'b110:  taken_c = (rs1_in <  rs2_in);
            3'b111:  taken_c = (rs1_in >= rs2_in);
            default: taken_c = 1'b0;
        endcase
        // funct3 010/011 are accepted but have no architectural effect
        legal_c   = (funct3_in[2:1] != 2'b01);
        next_pc_c = pc_in + (taken_c ? imm_in : 32'd4);
        upd_c     = valid_in && ready_q && legal_c;
        mis_c     = upd_c && (taken_c != pred_in);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mis_c) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= 3'd0;
            ready_q          <= 1'b0;
            flush_q          <= 1'b0;
            flag_q           <= 1'b1;
            addr_q           <= 8'd0;
            branch_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ready_q          <= (state_d == IDLE);
            flush_q          <= (state_d == FLUSH);
            flag_q           <= ~upd_c;
            redirect_valid_q <= mis_c;
            if (upd_c) begin
                addr_q   <= pc_in[IDX_LSB+7:IDX_LSB];
                branch_q <= taken_c;
            end
            if (mis_c) begin
                redirect_pc_q <= next_pc_c;
            end
        end
    end

    assign ready_out      = ready_q;
    assign flush          = flush_q;
    assign flag_to_pred   = flag_q;
    assign addr_to_pred   = addr_q;
    assign branch_to_pred = branch_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_br_q, stat_mis_q;

    // Counted at the end of the update cycle, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            if (!flag_q && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (redirect_valid_q && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, hand-written multi-cycle sequences, random stimulus vs. a reference model.
module tb_branch_resolver;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, pred_in;
    logic [31:0] pc_in, imm_in, rs1_in, rs2_in;
    logic [2:0]  funct3_in;
    logic        ready_out, flag_to_pred, branch_to_pred, redirect_valid, flush;
    logic [7:0]  addr_to_pred;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk           (clk),
        .rst           (rst_n),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .pc_in         (pc_in),
        .imm_in        (imm_in),
        .funct3_in     (funct3_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .pred_in       (pred_in),
        .flag_to_pred  (flag_to_pred),
        .addr_to_pred  (addr_to_pred),
        .branch_to_pred(branch_to_pred),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred;
        logic        exp_taken;
        logic [31:0] exp_npc;
        logic [7:0]  exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        valid_in  = v;
        funct3_in = f3;
        rs1_in    = a;
        rs2_in    = b;
        pc_in     = pc;
        imm_in    = imm;
        pred_in   = pred;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch condition from the ISA definition; signed compare done by biasing the sign bit
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa, sb;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"beq_taken_ok",  3'b000, 32'd5,        32'd5,        32'h0000_0100, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0120, 8'h40};
        vecs[1] = '{"blt_signed_mp", 3'b100, 32'hFFFF_FFFF, 32'd1,       32'h0000_0200, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h0000_01F0, 8'h80};
        vecs[2] = '{"bltu_nt_ok",    3'b110, 32'hFFFF_FFFF, 32'd1,       32'h0000_0200, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0000_0204, 8'h80};
        vecs[3] = '{"pc_wrap_mp",    3'b001, 32'd7,        32'd7,        32'hFFFF_FFFC, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0000, 8'hFF};
        vecs[4] = '{"bge_neg_mp",    3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_1000, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_1080, 8'h00};
        vecs[5] = '{"bgeu_nt_ok",    3'b111, 32'd1,        32'hFFFF_FFFF, 32'h0000_003C, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0040, 8'h0F};
        vecs[6] = '{"bge_eq_ok",     3'b101, 32'd9,        32'd9,        32'h0000_0010, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0000, 8'h04};
        vecs[7] = '{"beq_nt_mp",     3'b000, 32'd1,        32'd2,        32'h7FFF_FFF0, 32'h0000_0008, 1'b1, 1'b0, 32'h7FFF_FFF4, 8'hFC};

        drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_flag",  flag_to_pred,   1'b1);
        chk("rst_addr",  addr_to_pred,   8'd0);
        chk("rst_br",    branch_to_pred, 1'b0);
        chk("rst_rv",    redirect_valid, 1'b0);
        chk("rst_rpc",   redirect_pc,    32'd0);
        chk("rst_flush", flush,          1'b0);
        chk("rst_ready", ready_out,      1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", ready_out, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic mp;
            mp = (vecs[i].exp_taken != vecs[i].pred);
            drive(1'b1, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
            tick();
            valid_in = 1'b0;
            chk({vecs[i].name, "_flag"},  flag_to_pred,   1'b0);
            chk({vecs[i].name, "_addr"},  addr_to_pred,   vecs[i].exp_addr);
            chk({vecs[i].name, "_br"},    branch_to_pred, vecs[i].exp_taken);
            chk({vecs[i].name, "_rv"},    redirect_valid, mp);
            chk({vecs[i].name, "_flush"}, flush,          mp);
            chk({vecs[i].name, "_ready"}, ready_out,      !mp);
            if (mp) chk({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].exp_npc);
            tick();
            chk({vecs[i].name, "_flag2"}, flag_to_pred, 1'b1);
            chk({vecs[i].name, "_rv2"},   redirect_valid, 1'b0);
            if (mp) begin
                chk({vecs[i].name, "_flush2"}, flush,     1'b1);
                chk({vecs[i].name, "_ready2"}, ready_out, 1'b0);
                tick();
                chk({vecs[i].name, "_flush3"}, flush,     1'b0);
                chk({vecs[i].name, "_ready3"}, ready_out, 1'b1);
            end
        end

        // Back-to-back correctly predicted branches: one update per cycle
        drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h0000_0400, 32'd16, 1'b1);
        tick();
        pc_in = 32'h0000_0404;
        chk("b2b_flag0", flag_to_pred, 1'b0);
        chk("b2b_addr0", addr_to_pred, 8'h00);
        tick();
        valid_in = 1'b0;
        chk("b2b_flag1", flag_to_pred, 1'b0);
        chk("b2b_addr1", addr_to_pred, 8'h01);
        tick();

        // valid_in held across FLUSH: ignored until the first IDLE cycle
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'hFFFF_FFF0, 1'b0);
        tick();
        drive(1'b1, 3'b000, 32'd4, 32'd4, 32'h0000_0300, 32'h0000_0010, 1'b1);
        chk("hold_flag_n1",  flag_to_pred, 1'b0);
        chk("hold_flush_n1", flush,        1'b1);
        tick();
        chk("hold_flag_n2",  flag_to_pred, 1'b1);
        chk("hold_flush_n2", flush,        1'b1);
        tick();
        chk("hold_flag_n3",  flag_to_pred, 1'b1);
        chk("hold_ready_n3", ready_out,    1'b1);
        tick();
        valid_in = 1'b0;
        chk("hold_flag_n4",  flag_to_pred, 1'b0);
        chk("hold_addr_n4",  addr_to_pred, 8'hC0);
        chk("hold_br_n4",    branch_to_pred, 1'b1);
        tick();

        // Illegal funct3 values are swallowed
        for (int k = 2; k <= 3; k++) begin
            drive(1'b1, 3'(k), 32'd1, 32'd2, 32'h0000_0500, 32'h0000_0040, 1'b0);
            tick();
            chk("illegal_flag",  flag_to_pred,   1'b1);
            chk("illegal_rv",    redirect_valid, 1'b0);
            chk("illegal_ready", ready_out,      1'b1);
            chk("illegal_flush", flush,          1'b0);
        end
        valid_in = 1'b0;
        tick();

        // Asynchronous reset in the first FLUSH cycle
        drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h0000_0600, 32'h0000_0020, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("mid_flush_pre", flush,          1'b1);
        chk("mid_rv_pre",    redirect_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_flush_async", flush,          1'b0);
        chk("mid_rv_async",    redirect_valid, 1'b0);
        chk("mid_flag_async",  flag_to_pred,   1'b1);
        chk("mid_ready_async", ready_out,      1'b0);
        tick();
        chk("mid_ready_held", ready_out, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("mid_ready_rel", ready_out,      1'b1);
        chk("mid_flush_rel", flush,          1'b0);
        chk("mid_rv_rel",    redirect_valid, 1'b0);
        chk("mid_flag_rel",  flag_to_pred,   1'b1);

        // Random traffic against the reference model; DUT is idle here
        begin
            int          fl;
            logic        acc, legal, tk, upd, mis;
            logic [31:0] npc;
            fl = 0;
            for (int c = 0; c < 3000; c++) begin
                logic [31:0] a, b;
                a = $urandom;
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 3);
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if ($urandom_range(0, 5) == 0) b = -a;
                drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a, b,
                      $urandom, $urandom, 1'($urandom_range(0, 1)));
                acc   = valid_in && (fl == 0);
                legal = (funct3_in != 3'd2) && (funct3_in != 3'd3);
                tk    = ref_taken(funct3_in, rs1_in, rs2_in);
                npc   = pc_in + (tk ? imm_in : 32'd4);
                upd   = acc && legal;
                mis   = upd && (tk != pred_in);
                if (mis) fl = FC;
                else if (fl > 0) fl--;
                tick();
                chk("rnd_flag",  flag_to_pred,   !upd);
                chk("rnd_rv",    redirect_valid, mis);
                chk("rnd_flush", flush,          fl > 0);
                chk("rnd_ready", ready_out,      fl == 0);
                if (upd) begin
                    chk("rnd_addr", addr_to_pred,   pc_in[9:2]);
                    chk("rnd_br",   branch_to_pred, tk);
                end
                if (mis) chk("rnd_rpc", redirect_pc, npc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
